// File: rtl/muldiv_seq_if.sv
// Request/response bundle for muldiv_seq.
//   master: start, op, a, b          -> sequencer
//   slave : ready, done, res_hi, res_lo -> requester
interface muldiv_seq_if;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [15:0] res_hi;
  logic [15:0] res_lo;

  modport master (output start, op, a, b, input ready, done, res_hi, res_lo);
  modport slave  (input start, op, a, b, output ready, done, res_hi, res_lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: 16-cycle unsigned 16x16 multiply (shift-add) and, when
// MULDIV_DIV_EN is defined, restoring divide, both iterating one private
// 16-bit ALU once per cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - muldiv_seq_if.slave: start/op/a/b in, ready/done/res_hi/res_lo out
//          res_hi:res_lo = product, or remainder:quotient for divide
// Config macro: MULDIV_DIV_EN (undefined -> op ignored, multiply only).

// ALU: zb zeroes the b operand, nb inverts it, ic inhibits the carry-in.
module muldiv_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        ci,
  input  logic        nb,
  input  logic        ic,
  input  logic        zb,
  output logic [15:0] sum,
  output logic        co
);
  logic [15:0] yb;
  always_comb begin
    yb        = zb ? 16'h0000 : (nb ? ~y : y);
    {co, sum} = {1'b0, x} + {1'b0, yb} + {16'h0000, ci & ~ic};
  end
endmodule

module muldiv_seq (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [3:0]  cnt;
  logic [15:0] acc_hi;   // partial product high half / remainder
  logic [15:0] acc_lo;   // multiplier bits / quotient
  logic [15:0] opnd;     // multiplicand / divisor
  logic        is_div;

  logic [15:0] alu_x, alu_y, alu_sum;
  logic        alu_ci, alu_nb, alu_ic, alu_zb, alu_co;
  logic [15:0] next_hi, next_lo;

`ifdef MULDIV_DIV_EN
  logic op_q;
  assign is_div = op_q;
`else
  logic unused_op;
  assign unused_op = bus.op;
  assign is_div    = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (cnt == 4'd15) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);

  // ALU operand / control selection
  always_comb begin
    alu_x  = acc_hi;
    alu_y  = opnd;
    // multiply: add when the current multiplier bit is set, else pass acc_hi
    alu_ci = 1'b0;
    alu_nb = 1'b0;
    alu_ic = ~acc_lo[0];
    alu_zb = ~acc_lo[0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // shifted remainder minus divisor
      alu_x  = {acc_hi[14:0], acc_lo[15]};
      alu_ci = 1'b1;
      alu_nb = 1'b1;
      alu_ic = 1'b0;
      alu_zb = 1'b0;
    end
`endif
  end

  muldiv_alu u_alu (
    .x(alu_x), .y(alu_y), .ci(alu_ci), .nb(alu_nb), .ic(alu_ic), .zb(alu_zb),
    .sum(alu_sum), .co(alu_co)
  );

  // Per-iteration accumulator update
  always_comb begin
    next_hi = {alu_co & acc_lo[0], alu_sum[15:1]};
    next_lo = {alu_sum[0], acc_lo[15:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // bit shifted out of rem counts as part of the trial remainder
      next_hi = (acc_hi[15] | alu_co) ? alu_sum : alu_x;
      next_lo = {acc_lo[14:0], acc_hi[15] | alu_co};
    end
`endif
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      acc_hi     <= 16'h0000;
      acc_lo     <= 16'h0000;
      opnd       <= 16'h0000;
      bus.res_hi <= 16'h0000;
      bus.res_lo <= 16'h0000;
`ifdef MULDIV_DIV_EN
      op_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= 4'd0;
          acc_hi <= 16'h0000;
`ifdef MULDIV_DIV_EN
          op_q   <= bus.op;
          acc_lo <= bus.op ? bus.a : bus.b;
          opnd   <= bus.op ? bus.b : bus.a;
`else
          acc_lo <= bus.b;
          opnd   <= bus.a;
`endif
        end
        RUN: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            bus.res_hi <= next_hi;
            bus.res_lo <= next_lo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
